// File: rtl/stage_pkg.sv
// Shared definitions for the stage collision detector: wall bit indices,
// geometry entry layout/encodings and an entry constructor.
package stage_pkg;

  localparam int unsigned COORD_W = 16;
  localparam int unsigned IDX_W   = 4;

  // Bit positions inside the wall vector.
  localparam int unsigned WALL_UP    = 0;
  localparam int unsigned WALL_DOWN  = 1;
  localparam int unsigned WALL_RIGHT = 2;
  localparam int unsigned WALL_LEFT  = 3;
  localparam int unsigned WALL_PLAT  = 4;
  localparam int unsigned WALL_KO    = 5;

  localparam logic ENT_SOLID    = 1'b0;
  localparam logic ENT_PLATFORM = 1'b1;

  // 65-bit geometry entry; bounds are inclusive, y1 is the top edge.
  typedef struct packed {
    logic               typ;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] y1;
  } entry_t;

  function automatic entry_t build_entry(input logic typ,
                                         input logic [COORD_W-1:0] x0,
                                         input logic [COORD_W-1:0] x1,
                                         input logic [COORD_W-1:0] y0,
                                         input logic [COORD_W-1:0] y1);
    entry_t e;
    e.typ = typ;
    e.x0  = x0;
    e.x1  = x1;
    e.y0  = y0;
    e.y1  = y1;
    return e;
  endfunction

endpackage

// File: rtl/stage_geometry_rom.sv
// Combinational stage geometry table.
//   idx   in  entry index
//   entry out geometry entry for idx
// Unused slots hold an inverted box (x0>x1, y0>y1) that can never overlap,
// so scanning past the populated entries produces no flags.
module stage_geometry_rom
  import stage_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output entry_t           entry
);

  always_comb begin
    entry = build_entry(ENT_SOLID, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000);
    case (idx)
      4'd0: entry = build_entry(ENT_SOLID,    16'd40,  16'd279, 16'd0,   16'd39);
      4'd1: entry = build_entry(ENT_PLATFORM, 16'd80,  16'd139, 16'd96,  16'd100);
      4'd2: entry = build_entry(ENT_PLATFORM, 16'd180, 16'd239, 16'd96,  16'd100);
      4'd3: entry = build_entry(ENT_SOLID,    16'd140, 16'd179, 16'd160, 16'd179);
      default: ;
    endcase
  end

endmodule

// File: rtl/stage_collision_detector.sv
// Per-player stage collision detector. Every PERIOD clocks it snapshots the
// player position, scans N_ENT geometry entries (one per clock) and commits
// the contact flags to wall atomically.
//   clock      in  system clock
//   reset      in  synchronous active-high reset
//   position   in  {x[31:16], y[15:0]} of the player's feet
//   drop_thru  in  suppresses platform contact (sampled at snapshot)
//   wall       out [0] up [1] down [2] right [3] left [4] platform [5] ko
//   scan_busy  out high while a scan is in progress
module stage_collision_detector
  import stage_pkg::*;
#(
  parameter int unsigned N_ENT   = 4,
  parameter int unsigned HB_W    = 16,
  parameter int unsigned HB_H    = 24,
  parameter int unsigned TOL     = 2,
  parameter int unsigned PERIOD  = 2048,
  parameter int unsigned BLAST_X = 320,
  parameter int unsigned BLAST_Y = 240
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] position,
  input  logic        drop_thru,
  output logic [31:0] wall,
  output logic        scan_busy
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned EXT_W = COORD_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
  logic               dt_q, dt_d;
  logic [4:0]         acc_q, acc_d;
  logic [5:0]         wall_q, wall_d;
  logic               busy_q, busy_d;

  logic               tick;
  entry_t             ent;
  logic [4:0]         flags;

  stage_geometry_rom u_rom (
    .idx   (idx_q),
    .entry (ent)
  );

  assign tick      = (cnt_q == CNT_W'(PERIOD - 1));
  assign wall      = {26'd0, wall_q};
  assign scan_busy = busy_q;

  // Contact evaluation of the current entry; 17-bit operands avoid wrap.
  logic [EXT_W-1:0]        px_e, py_e, pr_e, ph_e;
  logic [EXT_W-1:0]        x0_e, x1_e, y0_e, y1_e;
  logic [EXT_W-1:0]        x0_lo, y0_lo, x1_hi, y1_hi;
  logic signed [EXT_W-1:0] x0_sub, y0_sub;
  logic                    xov, yov, on_top;

  always_comb begin
    px_e   = {1'b0, px_q};
    py_e   = {1'b0, py_q};
    pr_e   = px_e + EXT_W'(HB_W - 1);
    ph_e   = py_e + EXT_W'(HB_H - 1);
    x0_e   = {1'b0, ent.x0};
    x1_e   = {1'b0, ent.x1};
    y0_e   = {1'b0, ent.y0};
    y1_e   = {1'b0, ent.y1};
    x0_sub = $signed(x0_e) - $signed(EXT_W'(TOL));
    y0_sub = $signed(y0_e) - $signed(EXT_W'(TOL));
    x0_lo  = (x0_sub < 0) ? '0 : $unsigned(x0_sub);
    y0_lo  = (y0_sub < 0) ? '0 : $unsigned(y0_sub);
    x1_hi  = x1_e + EXT_W'(TOL);
    y1_hi  = y1_e + EXT_W'(TOL);
    xov    = (px_e <= x1_e) && (pr_e >= x0_e);
    yov    = (py_e <= y1_e) && (ph_e >= y0_e);
    on_top = xov && (y1_e <= py_e) && (py_e <= y1_hi);

    flags = '0;
    if (ent.typ == ENT_PLATFORM) begin
      flags[WALL_PLAT] = on_top && !dt_q;
    end else begin
      flags[WALL_DOWN]  = on_top;
      flags[WALL_UP]    = xov && (y0_lo <= ph_e) && (ph_e <= y0_e);
      flags[WALL_LEFT]  = yov && (x1_e <= px_e) && (px_e <= x1_hi);
      flags[WALL_RIGHT] = yov && (x0_lo <= pr_e) && (pr_e <= x0_e);
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    px_d    = px_q;
    py_d    = py_q;
    dt_d    = dt_q;
    acc_d   = acc_q;
    wall_d  = wall_q;
    busy_d  = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          px_d    = position[31:16];
          py_d    = position[15:0];
          dt_d    = drop_thru;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        acc_d = acc_q | flags;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N_ENT - 1)) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        wall_d  = {({1'b0, px_q} >= EXT_W'(BLAST_X)) ||
                   ({1'b0, py_q} >= EXT_W'(BLAST_Y)), acc_q};
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      dt_q    <= 1'b0;
      acc_q   <= '0;
      wall_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      px_q    <= px_d;
      py_q    <= py_d;
      dt_q    <= dt_d;
      acc_q   <= acc_d;
      wall_q  <= wall_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_stage_collision_detector.sv
// Self-checking bench for stage_collision_detector: directed vector table
// plus hand-written sequences for startup latency, mid-scan drop_thru and
// mid-scan reset.
module tb_stage_collision_detector;

  localparam int unsigned PERIOD = 2048;
  localparam int unsigned N_ENT  = 4;

  logic        clock;
  logic        reset;
  logic [31:0] position;
  logic        drop_thru;
  logic [31:0] wall;
  logic        scan_busy;

  int errors = 0;
  int checks = 0;

  stage_collision_detector dut (
    .clock     (clock),
    .reset     (reset),
    .position  (position),
    .drop_thru (drop_thru),
    .wall      (wall),
    .scan_busy (scan_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        dt;
    logic [31:0] exp_wall;
  } vec_t;

  vec_t vecs [9];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Wait (on falling edges) until scan_busy reaches lvl, bounded.
  task automatic wait_busy(input logic lvl);
    int n = 0;
    while (scan_busy !== lvl && n < 3 * PERIOD) begin
      @(negedge clock);
      n++;
    end
    if (scan_busy !== lvl) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting scan_busy=%0b: got %0b", lvl, scan_busy);
    end
  endtask

  task automatic run_scan(input logic [15:0] x, input logic [15:0] y, input logic dt);
    position  = {x, y};
    drop_thru = dt;
    wait_busy(1'b1);
    wait_busy(1'b0);
  endtask

  initial begin
    int k;
    int busy_k;
    vecs[0] = '{16'd100, 16'd40,  1'b0, 32'h02};
    vecs[1] = '{16'd100, 16'd43,  1'b0, 32'h00};
    vecs[2] = '{16'd100, 16'd100, 1'b0, 32'h10};
    vecs[3] = '{16'd100, 16'd100, 1'b1, 32'h00};
    vecs[4] = '{16'd280, 16'd20,  1'b0, 32'h08};
    vecs[5] = '{16'd24,  16'd20,  1'b0, 32'h04};
    vecs[6] = '{16'd150, 16'd136, 1'b0, 32'h01};
    vecs[7] = '{16'd330, 16'd10,  1'b0, 32'h20};
    vecs[8] = '{16'd0,   16'd0,   1'b0, 32'h00};

    reset     = 1'b1;
    position  = {16'd100, 16'd40};
    drop_thru = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check32("reset_wall", wall, 32'h0);
    check32("reset_busy", {31'd0, scan_busy}, 32'h0);
    reset = 1'b0;

    // First commit lands on clock PERIOD-1+N_ENT+2 after release.
    k = 0;
    busy_k = 0;
    while (wall === 32'h0 && k < 3 * PERIOD) begin
      @(posedge clock);
      k++;
      @(negedge clock);
      if (scan_busy === 1'b1 && busy_k == 0) busy_k = k;
    end
    check32("first_commit_clock", 32'(k), 32'(PERIOD - 1 + N_ENT + 2));
    check32("first_busy_clock", 32'(busy_k), 32'(PERIOD));
    check32("first_commit_wall", wall, 32'h02);
    check32("first_commit_busy", {31'd0, scan_busy}, 32'h0);

    foreach (vecs[i]) begin
      run_scan(vecs[i].x, vecs[i].y, vecs[i].dt);
      check32($sformatf("vec%0d_wall", i), wall, vecs[i].exp_wall);
      check32($sformatf("vec%0d_busy", i), {31'd0, scan_busy}, 32'h0);
    end

    // drop_thru changed mid-scan only affects the following snapshot.
    position  = {16'd100, 16'd100};
    drop_thru = 1'b0;
    wait_busy(1'b1);
    drop_thru = 1'b1;
    wait_busy(1'b0);
    check32("dt_midscan_ignored", wall, 32'h10);
    wait_busy(1'b1);
    wait_busy(1'b0);
    check32("dt_next_snapshot", wall, 32'h00);

    // Reset during SCAN at idx=2 aborts with no commit.
    run_scan(16'd100, 16'd40, 1'b0);
    check32("pre_abort_wall", wall, 32'h02);
    position  = {16'd280, 16'd20};
    drop_thru = 1'b0;
    wait_busy(1'b1);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check32("abort_wall", wall, 32'h0);
    check32("abort_busy", {31'd0, scan_busy}, 32'h0);
    reset = 1'b0;
    repeat (N_ENT + 2) @(negedge clock);
    check32("abort_no_commit", wall, 32'h0);
    wait_busy(1'b1);
    wait_busy(1'b0);
    check32("after_abort_wall", wall, 32'h08);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
